// File: rtl/npu_host_seq.sv
// Host-side sequencer: streams a program FIFO to the NPU, waits for ready,
// reads back result words into a first-word-fall-through result FIFO.
//
// state    | meaning
// IDLE     | waiting for start with a non-empty program FIFO
// LEAD     | NPU setup cycle, we=1 with zero data
// LOAD     | one program word popped and driven per cycle
// GAP      | bus released for one cycle, timeout counter cleared
// WAIT_RDY | waiting for npu_ready, optional timeout
// READ     | oe high, result words captured after RD_LAT
// DONE     | one-cycle done pulse
// ERR      | timeout: err_tmo set, program FIFO flushed
module npu_host_seq #(
    parameter int DATA_W     = 32,
    parameter int PROG_DEPTH = 64,
    parameter int OUT_DEPTH  = 16,
    parameter int RD_LAT     = 1,
    parameter int TMO_W      = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         prog_valid,
    input  logic [DATA_W-1:0]            prog_data,
    output logic                         prog_ready,
    input  logic                         start,
    input  logic [$clog2(OUT_DEPTH):0]   num_out,
    input  logic [TMO_W-1:0]             tmo_limit,
    output logic                         npu_we,
    output logic                         npu_oe,
    output logic [DATA_W-1:0]            npu_dout,
    output logic                         npu_dout_en,
    input  logic [DATA_W-1:0]            npu_din,
    input  logic                         npu_ready,
    output logic                         res_valid,
    output logic [DATA_W-1:0]            res_data,
    input  logic                         res_ready,
    output logic                         busy,
    output logic                         done,
    output logic                         err_tmo
);
    localparam int PW = $clog2(PROG_DEPTH);
    localparam int OW = $clog2(OUT_DEPTH);
    localparam int NW = OW + 1;
    localparam logic [PW:0] PROG_FULL = (PW+1)'(PROG_DEPTH);
    localparam logic [OW:0] RES_FULL  = (OW+1)'(OUT_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_LEAD, S_LOAD, S_GAP, S_WAIT_RDY, S_READ, S_DONE, S_ERR
    } state_t;

    state_t state, state_nx;

    logic [DATA_W-1:0] prog_mem [PROG_DEPTH];
    logic [PW-1:0]     prog_wp, prog_rp;
    logic [PW:0]       prog_cnt;
    logic              prog_push, prog_pop, prog_flush;

    logic [DATA_W-1:0] res_mem [OUT_DEPTH];
    logic [OW-1:0]     res_wp, res_rp;
    logic [OW:0]       res_cnt;
    logic              res_push, res_pop, res_full;

    logic [NW-1:0]     num_lat, cap_idx;
    logic [TMO_W-1:0]  tmo_lat, tmo_cnt;
    logic [2:0]        rd_cnt;

    assign prog_ready = (prog_cnt != PROG_FULL);
    assign prog_push  = prog_valid & prog_ready;
    assign res_valid  = (res_cnt != '0);
    assign res_full   = (res_cnt == RES_FULL);
    assign res_pop    = res_valid & res_ready;
    assign res_data   = res_mem[res_rp];
    assign busy       = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (prog_push) prog_mem[prog_wp] <= prog_data;
        if (res_push)  res_mem[res_wp]   <= npu_din;
    end

    always_ff @(posedge clk) begin
        if (rst || prog_flush) begin
            prog_wp  <= '0;
            prog_rp  <= '0;
            prog_cnt <= '0;
        end else begin
            if (prog_push) prog_wp <= prog_wp + PW'(1);
            if (prog_pop)  prog_rp <= prog_rp + PW'(1);
            prog_cnt <= prog_cnt + (PW+1)'(prog_push) - (PW+1)'(prog_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res_wp  <= '0;
            res_rp  <= '0;
            res_cnt <= '0;
        end else begin
            if (res_push) res_wp <= res_wp + OW'(1);
            if (res_pop)  res_rp <= res_rp + OW'(1);
            res_cnt <= res_cnt + (OW+1)'(res_push) - (OW+1)'(res_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            num_lat <= '0;
            tmo_lat <= '0;
            tmo_cnt <= '0;
            rd_cnt  <= '0;
            cap_idx <= '0;
            err_tmo <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == S_IDLE && start) begin
                err_tmo <= 1'b0;
                num_lat <= num_out;
                tmo_lat <= tmo_limit;
            end
            if (state == S_WAIT_RDY && state_nx == S_ERR) err_tmo <= 1'b1;
            if (state == S_GAP)
                tmo_cnt <= '0;
            else if (state == S_WAIT_RDY && !npu_ready)
                tmo_cnt <= tmo_cnt + TMO_W'(1);
            // rd_cnt numbers oe cycles from 1 and saturates at RD_LAT
            if (state != S_READ && state_nx == S_READ)
                rd_cnt <= 3'd1;
            else if (state == S_READ && rd_cnt < 3'(RD_LAT))
                rd_cnt <= rd_cnt + 3'd1;
            if (state != S_READ)
                cap_idx <= '0;
            else if (res_push)
                cap_idx <= cap_idx + NW'(1);
        end
    end

    always_comb begin
        state_nx    = state;
        npu_we      = 1'b0;
        npu_oe      = 1'b0;
        npu_dout_en = 1'b0;
        npu_dout    = '0;
        prog_pop    = 1'b0;
        prog_flush  = 1'b0;
        res_push    = 1'b0;
        done        = 1'b0;
        case (state)
            S_IDLE: begin
                if (start && prog_cnt != '0) state_nx = S_LEAD;
            end
            S_LEAD: begin
                npu_we      = 1'b1;
                npu_dout_en = 1'b1;
                state_nx    = S_LOAD;
            end
            S_LOAD: begin
                npu_we      = 1'b1;
                npu_dout_en = 1'b1;
                npu_dout    = prog_mem[prog_rp];
                prog_pop    = 1'b1;
                // leave once this pop empties the FIFO and nothing refills it
                if (prog_cnt == (PW+1)'(1) && !prog_push) state_nx = S_GAP;
            end
            S_GAP: state_nx = S_WAIT_RDY;
            S_WAIT_RDY: begin
                if (npu_ready)
                    state_nx = (num_lat == '0) ? S_DONE : S_READ;
                else if (tmo_lat != '0 && tmo_cnt == tmo_lat - TMO_W'(1))
                    state_nx = S_ERR;
            end
            S_READ: begin
                npu_oe = 1'b1;
                if (rd_cnt >= 3'(RD_LAT) && !res_full) begin
                    res_push = 1'b1;
                    if (cap_idx == num_lat - NW'(1)) state_nx = S_DONE;
                end
            end
            S_DONE: begin
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            S_ERR: begin
                prog_flush = 1'b1;
                state_nx   = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_npu_host_seq.sv
// Bench for npu_host_seq: NPU stub, result scoreboard, directed scenarios.
module tb_npu_host_seq;
    localparam int DW = 32, PD = 16, OD = 4, RD_LAT = 3, TW = 16;

    logic          clk = 1'b0;
    logic          rst, prog_valid, prog_ready, start;
    logic [DW-1:0] prog_data, npu_dout, npu_din, res_data;
    logic [2:0]    num_out;
    logic [TW-1:0] tmo_limit;
    logic          npu_we, npu_oe, npu_dout_en, npu_ready;
    logic          res_valid, res_ready, busy, done, err_tmo;

    npu_host_seq #(.DATA_W(DW), .PROG_DEPTH(PD), .OUT_DEPTH(OD),
                   .RD_LAT(RD_LAT), .TMO_W(TW)) dut (
        .clk(clk), .rst(rst), .prog_valid(prog_valid), .prog_data(prog_data),
        .prog_ready(prog_ready), .start(start), .num_out(num_out),
        .tmo_limit(tmo_limit), .npu_we(npu_we), .npu_oe(npu_oe),
        .npu_dout(npu_dout), .npu_dout_en(npu_dout_en), .npu_din(npu_din),
        .npu_ready(npu_ready), .res_valid(res_valid), .res_data(res_data),
        .res_ready(res_ready), .busy(busy), .done(done), .err_tmo(err_tmo)
    );

    always #5 clk = ~clk;

    int n_tests = 0, n_fail = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] exp_w;

    // NPU stub state
    logic [DW-1:0] words [8];
    logic [DW-1:0] we_log[$];
    int cap_log[$];
    int idx, occ, oe_cyc, oe_last, rcnt, rdy_delay, we_cnt;
    logic prev_we, cap, pop_now;

    always @(negedge clk) begin
        if (rst) begin
            occ = 0; idx = 0; oe_cyc = 0; rcnt = -1; npu_ready = 1'b0; prev_we = 1'b0;
        end else begin
            if (busy) begin
                n_tests++;
                if ((npu_we && npu_oe) || (!npu_we && npu_dout_en)) begin
                    n_fail++;
                    $display("FAIL bus_rules we=%0b oe=%0b en=%0b required no we&oe, no en without we",
                             npu_we, npu_oe, npu_dout_en);
                end
            end
            if (npu_we) begin we_cnt++; we_log.push_back(npu_dout); end
            if (prev_we && !npu_we) rcnt = rdy_delay;
            else if (rcnt > 0) rcnt--;
            if (rcnt == 0) begin npu_ready = 1'b1; rcnt = -1; end
            prev_we = npu_we;
            if (npu_oe) begin oe_cyc++; oe_last = oe_cyc; end
            npu_din = (idx < 8) ? words[idx] : '0;
            cap     = npu_oe && (oe_cyc >= RD_LAT) && (occ < OD);
            pop_now = res_valid && res_ready;
            if (cap) begin cap_log.push_back(oe_cyc); idx++; end
            occ = occ + int'(cap) - int'(pop_now);
            if (!busy) begin npu_ready = 1'b0; oe_cyc = 0; idx = 0; end
        end
    end

    // scoreboard monitor
    always @(negedge clk) begin
        if (!rst && res_valid && res_ready) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL res_unexpected got=%h required=none", res_data);
            end else begin
                exp_w = exp_q.pop_front();
                if (res_data !== exp_w) begin
                    n_fail++;
                    $display("FAIL res_data got=%h required=%h", res_data, exp_w);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic push_word(input logic [31:0] w);
        prog_valid = 1'b1;
        prog_data  = w;
        tick(1);
        prog_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic run_to_idle(input int max_cyc, output int dn, output int gap);
        int t_done;
        t_done = -1; dn = 0; gap = -1;
        for (int i = 0; i < max_cyc; i++) begin
            tick(1);
            if (done) begin dn++; t_done = i; end
            if (!busy) begin gap = i - t_done; return; end
        end
        check("run_timeout", 32'(busy), 32'd0);
    endtask

    int dn, gap, t_fall, t_err, found;
    logic pw;
    logic [31:0] ref_prog [9];

    initial begin
        rst = 1'b1; prog_valid = 1'b0; prog_data = '0; start = 1'b0;
        num_out = '0; tmo_limit = '0; res_ready = 1'b1; rdy_delay = -1;
        we_cnt = 0; oe_last = 0;
        for (int i = 0; i < 8; i++) words[i] = '0;
        tick(2);
        check("rst_prog_ready", 32'(prog_ready), 32'd1);
        check("rst_busy",       32'(busy),       32'd0);
        check("rst_we_oe_en",   {29'd0, npu_we, npu_oe, npu_dout_en}, 32'd0);
        check("rst_res_valid",  32'(res_valid),  32'd0);
        check("rst_done_err",   {30'd0, done, err_tmo}, 32'd0);
        rst = 1'b0;
        tick(1);

        // reference load
        ref_prog = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                     32'h40000000, 32'h45800000, 32'h44800000};
        for (int i = 0; i < 9; i++) push_word(ref_prog[i]);
        words[0] = 32'h45A00000; exp_q.push_back(32'h45A00000);
        rdy_delay = 5; num_out = 3'd1; tmo_limit = '0;
        we_cnt = 0; we_log.delete();
        pulse_start();
        run_to_idle(100, dn, gap);
        check("ref_done_pulses", dn, 1);
        check("ref_busy_fall",   gap, 1);
        check("ref_we_cycles",   we_cnt, 10);
        check("ref_lead_word",   (we_log.size() > 0) ? we_log[0] : 32'hFFFFFFFF, 32'h0);
        for (int i = 0; i < 9; i++)
            check("ref_word", (we_log.size() > i + 1) ? we_log[i+1] : 32'hFFFFFFFF, ref_prog[i]);

        // RD_LAT=3, two result words
        push_word(32'hC0DE0001);
        words[0] = 32'h11111111; words[1] = 32'h22222222;
        exp_q.push_back(32'h11111111); exp_q.push_back(32'h22222222);
        rdy_delay = 2; num_out = 3'd2; oe_last = 0; cap_log.delete();
        pulse_start();
        run_to_idle(100, dn, gap);
        check("lat_oe_cycles", oe_last, 4);
        check("lat_cap_count", cap_log.size(), 2);
        check("lat_cap0", (cap_log.size() > 0) ? cap_log[0] : -1, 3);
        check("lat_cap1", (cap_log.size() > 1) ? cap_log[1] : -1, 4);

        // back-pressure: six words through a four-deep result FIFO
        push_word(32'hC0DE0002);
        for (int i = 0; i < 6; i++) begin
            words[i] = 32'h60000000 + i;
            exp_q.push_back(32'h60000000 + i);
        end
        rdy_delay = 3; num_out = 3'd6; res_ready = 1'b0; cap_log.delete();
        pulse_start();
        for (int i = 0; i < 60 && cap_log.size() < 4; i++) tick(1);
        tick(4);
        check("bp_stall_caps", cap_log.size(), 4);
        check("bp_oe_held",    32'(npu_oe), 32'd1);
        check("bp_res_valid",  32'(res_valid), 32'd1);
        res_ready = 1'b1;
        run_to_idle(100, dn, gap);
        check("bp_total_caps", cap_log.size(), 6);
        check("bp_done", dn, 1);
        tick(2);
        check("bp_queue_drained", exp_q.size(), 0);

        // ready timeout
        for (int i = 0; i < 3; i++) push_word(32'hD0000000 + i);
        rdy_delay = -1; tmo_limit = 16'd8; num_out = 3'd1;
        pulse_start();
        t_fall = -1; t_err = -1; dn = 0; pw = npu_we;
        for (int i = 0; i < 60; i++) begin
            tick(1);
            if (pw && !npu_we && t_fall < 0) t_fall = i;
            pw = npu_we;
            if (t_fall >= 0 && i == t_fall + 3) begin
                prog_valid = 1'b1; prog_data = 32'hEEEE0001;
            end
            if (t_fall >= 0 && i == t_fall + 5) prog_valid = 1'b0;
            if (err_tmo && t_err < 0) t_err = i;
            if (done) dn++;
            if (!busy) break;
        end
        prog_valid = 1'b0;
        check("tmo_latency", t_err - t_fall, 9);
        check("tmo_no_done", dn, 0);
        check("tmo_sticky",  32'(err_tmo), 32'd1);
        pulse_start();
        check("tmo_cleared", 32'(err_tmo), 32'd0);
        check("tmo_flushed_busy", 32'(busy), 32'd0);
        tick(2);
        check("tmo_flushed_busy2", 32'(busy), 32'd0);
        tmo_limit = '0;

        // program FIFO full, then empty start
        for (int i = 0; i < PD + 2; i++) begin
            check("full_prog_ready", 32'(prog_ready), (i < PD) ? 32'd1 : 32'd0);
            push_word(32'hA000 + i);
        end
        check("full_after", 32'(prog_ready), 32'd0);
        rdy_delay = 1; num_out = 3'd0; we_cnt = 0; we_log.delete();
        pulse_start();
        run_to_idle(200, dn, gap);
        check("full_we_cycles", we_cnt, PD + 1);
        for (int i = 0; i < PD; i++)
            check("full_word", (we_log.size() > i + 1) ? we_log[i+1] : 32'hFFFFFFFF, 32'hA000 + i);
        check("full_done", dn, 1);
        pulse_start();
        check("empty_start_busy", 32'(busy), 32'd0);
        tick(1);
        check("empty_start_busy2", 32'(busy), 32'd0);

        // leave one result parked in the FIFO
        push_word(32'hC0DE0003);
        words[0] = 32'hDEAD0001; rdy_delay = 1; num_out = 3'd1; res_ready = 1'b0;
        pulse_start();
        run_to_idle(100, dn, gap);
        check("park_valid", 32'(res_valid), 32'd1);
        check("park_data",  res_data, 32'hDEAD0001);

        // reset on the third load word
        for (int i = 0; i < 8; i++) push_word(32'hB0000000 + i);
        pulse_start();
        found = 0;
        for (int i = 0; i < 20; i++) begin
            if (npu_we && npu_dout == 32'hB0000002) begin found = 1; break; end
            tick(1);
        end
        check("rst_found_word3", found, 1);
        rst = 1'b1;
        tick(1);
        check("mid_we",         32'(npu_we),      32'd0);
        check("mid_en",         32'(npu_dout_en), 32'd0);
        check("mid_busy",       32'(busy),        32'd0);
        check("mid_prog_ready", 32'(prog_ready),  32'd1);
        check("mid_res_valid",  32'(res_valid),   32'd0);
        rst = 1'b0;
        res_ready = 1'b1;
        tick(1);
        pulse_start();
        check("mid_prog_discarded", 32'(busy), 32'd0);
        tick(2);
        check("end_queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/npu_host_seq.md
Name: npu_host_seq

Overview:
Parametrised host-side sequencer that drives the NPU load/read bus protocol in hardware, replacing hand-timed stimulus. Host pushes a program (layer config, weights, biases, inputs) into an internal FIFO and pulses start. The block streams the words to the NPU under we, waits for ready, then asserts oe and captures the result words into an output FIFO with valid/ready handshake. It sits between the system/host interface and the npu top.

Parameters:
DATA_W, 32, bus/word width
PROG_DEPTH, 64, program FIFO depth (power of 2)
OUT_DEPTH, 16, result FIFO depth (power of 2)
RD_LAT, 1, cycles from oe rising to first valid NPU output word (1..4)
TMO_W, 16, width of ready-timeout counter

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
prog_valid  in  1  program word push strobe
prog_data  in  DATA_W  program word
prog_ready  out  1  program FIFO not full
start  in  1  one-cycle pulse; begin run
num_out  in  $clog2(OUT_DEPTH)+1  result words to read, sampled at start
tmo_limit  in  TMO_W  max cycles waiting for npu_ready, sampled at start
npu_we  out  1  NPU write enable
npu_oe  out  1  NPU output enable
npu_dout  out  DATA_W  word driven to NPU
npu_dout_en  out  1  1 = drive npu_dout onto shared bus, 0 = release (top-level tristate)
npu_din  in  DATA_W  word read from NPU
npu_ready  in  1  NPU result ready
res_valid  out  1  result FIFO not empty
res_data  out  DATA_W  head of result FIFO
res_ready  in  1  pop result
busy  out  1  state not IDLE
done  out  1  one-cycle pulse on successful completion
err_tmo  out  1  sticky timeout flag; cleared by start or rst

Behaviour:
- Reset: all outputs 0 except prog_ready=1; both FIFOs empty; state IDLE; counters 0. Reset mid-run aborts immediately: npu_we/npu_oe/npu_dout_en drop on the next edge, FIFO contents discarded.
- Program FIFO: push when prog_valid&prog_ready; push ignored when full. Pushes accepted in any state; words pushed during LOAD are streamed in the same run.
- States: IDLE -> LEAD -> LOAD -> GAP -> WAIT_RDY -> READ -> DONE -> IDLE; WAIT_RDY -> ERR -> IDLE.
- IDLE: start with program FIFO non-empty -> LEAD, clears err_tmo, latches num_out/tmo_limit. start with empty FIFO -> ignored (stays IDLE, err_tmo cleared). start while busy -> ignored.
- LEAD: one cycle, npu_we=1, npu_dout_en=1, npu_dout=0 (setup cycle required by NPU).
- LOAD: npu_we=1, npu_dout_en=1; one FIFO word popped and driven per cycle. FIFO empty -> GAP; a word arriving same cycle as last pop counts as non-empty only if visible at the next state evaluation (no bubble insertion: empty check is registered count==0).
- GAP: one cycle, npu_we=0, npu_dout_en=0. -> WAIT_RDY, timeout counter cleared.
- WAIT_RDY: counter increments each cycle npu_ready=0. npu_ready=1 -> READ (num_out=0 -> DONE). Counter reaches tmo_limit -> ERR. tmo_limit=0 disables timeout.
- READ: npu_oe=1 for RD_LAT+num_out-1 cycles; npu_din captured on cycles RD_LAT..RD_LAT+num_out-1 after oe rise. Result FIFO full at a capture cycle: capture stalls, npu_oe held, word index not advanced (NPU holds output while oe high). -> DONE after last capture; npu_oe drops same edge.
- DONE: one cycle, done=1 -> IDLE.
- ERR: one cycle, err_tmo set (sticky), program FIFO flushed -> IDLE. done not pulsed.
- Result FIFO: res_data = head (first-word-fall-through); pop on res_valid&res_ready; simultaneous push/pop when full is allowed and keeps count.
- npu_we and npu_oe never both 1; npu_dout_en=0 whenever npu_we=0.

Test Plan:
- Reference load: push 0,0,0,0,0,0,0x40000000,0x45800000,0x44800000, num_out=1, start; stub returns 0x45A00000 with ready 5 cycles after GAP -> npu_we high 10 cycles (LEAD + 9 words in order), res_data=0x45A00000, done pulses once, busy falls next cycle.
- Timeout: tmo_limit=8, stub never asserts ready -> err_tmo=1 exactly 8 cycles after WAIT_RDY entry, no done, program FIFO empty, next start clears err_tmo.
- Back-pressure: OUT_DEPTH=4, num_out=6, res_ready=0 until FIFO full -> npu_oe held, capture stalls at 4 words; release res_ready -> all 6 words read in order, no loss or duplication.
- Full/empty: push PROG_DEPTH+2 words -> prog_ready=0 after PROG_DEPTH, extra 2 dropped, exactly PROG_DEPTH words streamed; start with empty FIFO -> busy stays 0.
- Reset mid-LOAD: assert rst on 3rd load word -> next cycle npu_we=0, npu_dout_en=0, busy=0, prog_ready=1, res_valid=0.
- RD_LAT=3, num_out=2 -> captures on cycles 3 and 4 after oe rise; npu_oe high 4 cycles.
